// File: rtl/seq_lock_pkg.sv
// ----------------------------------------------------------------------------
// seq_lock_pkg
// Shared definitions for the bus-read sequence lock (seq_unlock_gate):
//   - state_t    : lock FSM states
//   - LFSR_TAPS  : feedback taps of the 8-bit response LFSR
//                  (x^8+x^6+x^5+x^4+1 -> new bit = b7^b5^b4^b3)
//   - key_field  : extracts key step <idx> from a packed key, where step 0
//                  is the most significant field
// ----------------------------------------------------------------------------
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Widest packed key the helper accepts (KEY_LEN * CODE_W).
  localparam int unsigned KEY_MAX_W = 64;

  function automatic logic [31:0] key_field(
    input logic [KEY_MAX_W-1:0] key,
    input int unsigned          code_w,
    input int unsigned          key_len,
    input int unsigned          idx
  );
    logic [KEY_MAX_W-1:0] shifted;
    logic [KEY_MAX_W-1:0] mask;
    shifted = key >> ((key_len - 1 - idx) * code_w);
    mask    = ~({KEY_MAX_W{1'b1}} << code_w);
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/seq_unlock_gate_resp_lfsr.sv
// ----------------------------------------------------------------------------
// resp_lfsr
// 8-bit Fibonacci LFSR producing the response stream of an open gate.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//   load       : reload SEED (has priority over adv)
//   adv        : advance one step; new bit shifted in at the LSB
//   data       : low OUT_W bits of the current LFSR value
// ----------------------------------------------------------------------------
module resp_lfsr
  import seq_lock_pkg::*;
#(
  parameter logic [7:0]  SEED  = 8'h01,
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  output logic [OUT_W-1:0] data
);

  logic [7:0] lfsr;
  logic       feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (adv) begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

  assign data = lfsr[OUT_W-1:0];

endmodule

// File: rtl/seq_unlock_gate.sv
// ----------------------------------------------------------------------------
// seq_unlock_gate
// Bus-read sequence lock ("knock" detector). Qualified reads inside the
// address window present a code field; KEY_LEN correct codes in order open
// the gate, after which reads return a pseudo-random response stream.
// Repeated mismatches cause a timed lockout; an open gate closes on the
// relock code or after IDLE_TO cycles without an access.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus_strb    : one-cycle pulse per bus access
//   sel_n       : chip-select, active low
//   rd_wn       : 1 = read, 0 = write
//   addr        : bus address
//   data_out    : response data (LFSR when open, step when armed, 0 locked)
//   data_oe     : response drive enable (window read decode, no strobe)
//   unlocked    : gate open
//   locked_out  : lockout active
//   step        : current key step index
// ----------------------------------------------------------------------------
module seq_unlock_gate
  import seq_lock_pkg::*;
#(
  parameter int unsigned                 ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]           WIN_MASK    = 16'hF000,
  parameter logic [ADDR_W-1:0]           WIN_MATCH   = 16'h1000,
  parameter int unsigned                 CODE_LSB    = 4,
  parameter int unsigned                 CODE_W      = 4,
  parameter int unsigned                 KEY_LEN     = 4,
  parameter logic [KEY_LEN*CODE_W-1:0]   KEY         = 16'h29A8,
  parameter logic [CODE_W-1:0]           RELOCK_CODE = 4'hF,
  parameter int unsigned                 MAX_FAIL    = 3,
  parameter int unsigned                 LOCKOUT_CYC = 64,
  parameter int unsigned                 IDLE_TO     = 1024,
  parameter logic [7:0]                  LFSR_SEED   = 8'h01,
  parameter int unsigned                 RESP_W      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bus_strb,
  input  logic                       sel_n,
  input  logic                       rd_wn,
  input  logic [ADDR_W-1:0]          addr,
  output logic [RESP_W-1:0]          data_out,
  output logic                       data_oe,
  output logic                       unlocked,
  output logic                       locked_out,
  output logic [$clog2(KEY_LEN)-1:0] step
);

  localparam int unsigned STEP_W  = $clog2(KEY_LEN);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_MAX = (IDLE_TO > LOCKOUT_CYC) ? IDLE_TO : LOCKOUT_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic              hit;
  logic              acc;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] code_exp;
  logic [CODE_W-1:0] code_first;
  logic              code_match;
  logic              last_step;

  assign hit        = ~sel_n & rd_wn & ((addr & WIN_MASK) == WIN_MATCH);
  assign acc        = bus_strb & hit;
  assign code       = addr[CODE_LSB +: CODE_W];
  assign code_exp   = CODE_W'(key_field(KEY_MAX_W'(KEY), CODE_W, KEY_LEN, 32'(step)));
  assign code_first = CODE_W'(key_field(KEY_MAX_W'(KEY), CODE_W, KEY_LEN, 0));
  assign code_match = (code == code_exp);
  assign last_step  = (step == STEP_W'(KEY_LEN - 1));

  assign data_oe = hit;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] step_nx;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_nx;
  // One timer serves both the open-state idle countdown and the lockout
  // countdown; the two states never overlap.
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_nx;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic [RESP_W-1:0] lfsr_data;

  always_comb begin
    state_nx  = state;
    step_nx   = step;
    fail_nx   = fail_cnt;
    timer_nx  = timer;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    case (state)
      ARM: begin
        if (acc) begin
          if (code_match) begin
            if (last_step) begin
              state_nx  = OPEN;
              step_nx   = '0;
              fail_nx   = '0;
              lfsr_load = 1'b1;
              timer_nx  = TMR_W'(IDLE_TO);
            end else begin
              step_nx = step + STEP_W'(1);
            end
          end else begin
            fail_nx = fail_cnt + FAIL_W'(1);
            if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
              state_nx = LOCKOUT;
              timer_nx = TMR_W'(LOCKOUT_CYC - 1);
              step_nx  = '0;
            end else begin
              // A mismatching code that equals the first key field starts
              // a fresh attempt instead of being wasted.
              step_nx = (code == code_first) ? STEP_W'(1) : '0;
            end
          end
        end
      end

      OPEN: begin
        if (acc) begin
          if (code == RELOCK_CODE) begin
            state_nx = ARM;
            step_nx  = '0;
            timer_nx = '0;
          end else begin
            lfsr_adv = 1'b1;
            timer_nx = TMR_W'(IDLE_TO);
          end
        end else if (IDLE_TO != 0) begin
          if (timer <= TMR_W'(1)) begin
            state_nx = ARM;
            step_nx  = '0;
            timer_nx = '0;
          end else begin
            timer_nx = timer - TMR_W'(1);
          end
        end
      end

      LOCKOUT: begin
        if (timer == '0) begin
          state_nx = ARM;
          fail_nx  = '0;
          step_nx  = '0;
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end

      default: begin
        state_nx = ARM;
        step_nx  = '0;
        fail_nx  = '0;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARM;
      step       <= '0;
      fail_cnt   <= '0;
      timer      <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_nx;
      step       <= step_nx;
      fail_cnt   <= fail_nx;
      timer      <= timer_nx;
      unlocked   <= (state_nx == OPEN);
      locked_out <= (state_nx == LOCKOUT);
    end
  end

  // --------------------------------------------------------------------------
  // Response generator
  // --------------------------------------------------------------------------
  resp_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (RESP_W)
  ) u_resp_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .data  (lfsr_data)
  );

  // Driven from registered state only, so during a strobe the open gate
  // presents the LFSR value from before that access advances it.
  always_comb begin
    data_out = '0;
    case (state)
      ARM:     data_out = RESP_W'(step);
      OPEN:    data_out = lfsr_data;
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_seq_unlock_gate.sv
// ----------------------------------------------------------------------------
// tb_seq_unlock_gate
// Directed bench for seq_unlock_gate with default parameters
// (key codes 2,9,A,8 at addresses 0x10c0; relock code F).
// ----------------------------------------------------------------------------
module tb_seq_unlock_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_strb = 1'b0;
  logic        sel_n = 1'b1;
  logic        rd_wn = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [1:0]  data_out;
  logic        data_oe;
  logic        unlocked;
  logic        locked_out;
  logic [1:0]  step;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_unlock_gate dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_strb   (bus_strb),
    .sel_n      (sel_n),
    .rd_wn      (rd_wn),
    .addr       (addr),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .step       (step)
  );

  // ---------------------------------------------------------------- stimulus
  task automatic idle_bus();
    bus_strb = 1'b0;
    sel_n    = 1'b1;
    rd_wn    = 1'b1;
    addr     = 16'h0000;
  endtask

  task automatic start_acc(input logic [15:0] a, input logic rd, input logic strb);
    bus_strb = strb;
    sel_n    = 1'b0;
    rd_wn    = rd;
    addr     = a;
    #1;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic bus_read(input logic [15:0] a);
    start_acc(a, 1'b1, 1'b1);
    end_cycle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) end_cycle();
  endtask

  task automatic apply_reset();
    idle_bus();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic unlock_seq();
    bus_read(16'h1020);
    bus_read(16'h1090);
    bus_read(16'h10A0);
    bus_read(16'h1080);
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    #12;
    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", unlocked); end
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked_out: got %b expected 0", locked_out); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL reset_data_out: got %b expected 00", data_out); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe_idle: got %b expected 0", data_oe); end
    sel_n = 1'b0; rd_wn = 1'b1; addr = 16'h1234; #1;
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL reset_data_oe_hit: got %b expected 1", data_oe); end
    addr = 16'h2234; #1;
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe_miss: got %b expected 0", data_oe); end
    apply_reset();
  endtask

  task automatic test_unlock();
    logic [15:0] seq_a [3];
    logic [1:0]  resp_exp [5];
    seq_a    = '{16'h1020, 16'h1090, 16'h10A0};
    // LFSR 01 -> 02 -> 04 -> 08 -> 11 -> 23, low two bits
    resp_exp = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus_read(seq_a[i]);
      checks++; if (step !== 2'(i + 1)) begin errors++; $display("FAIL unlock_step%0d: got %0d expected %0d", i, step, i + 1); end
      checks++; if (data_out !== 2'(i + 1)) begin errors++; $display("FAIL unlock_arm_data%0d: got %b expected %0d", i, data_out, i + 1); end
    end
    bus_read(16'h1080);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_open: got %b expected 1", unlocked); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL unlock_open_step: got %0d expected 0", step); end
    checks++; if (data_out !== 2'b01) begin errors++; $display("FAIL unlock_seed_data: got %b expected 01", data_out); end
    for (int i = 0; i < 5; i++) begin
      start_acc(16'h1030, 1'b1, 1'b1);
      checks++; if (data_out !== resp_exp[i]) begin errors++; $display("FAIL resp_stream%0d: got %b expected %b", i, data_out, resp_exp[i]); end
      end_cycle();
    end
    checks++; if (data_out !== 2'b11) begin errors++; $display("FAIL resp_after: got %b expected 11", data_out); end
    start_acc(16'h10F0, 1'b1, 1'b1);
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL relock_data_oe: got %b expected 1", data_oe); end
    checks++; if (data_out !== 2'b11) begin errors++; $display("FAIL relock_pre_data: got %b expected 11", data_out); end
    end_cycle();
    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL relock_unlocked: got %b expected 0", unlocked); end
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL relock_data: got %b expected 00", data_out); end
  endtask

  task automatic test_ignore();
    apply_reset();
    start_acc(16'h1020, 1'b0, 1'b1);
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL ignore_write_oe: got %b expected 0", data_oe); end
    end_cycle();
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL ignore_write_step: got %0d expected 0", step); end
    start_acc(16'h2020, 1'b1, 1'b1);
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL ignore_window_oe: got %b expected 0", data_oe); end
    end_cycle();
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL ignore_window_step: got %0d expected 0", step); end
    start_acc(16'h1020, 1'b1, 1'b0);
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL ignore_nostrb_oe: got %b expected 1", data_oe); end
    end_cycle();
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL ignore_nostrb_step: got %0d expected 0", step); end
  endtask

  task automatic test_overlap();
    apply_reset();
    bus_read(16'h1020);
    checks++; if (step !== 2'd1) begin errors++; $display("FAIL overlap_first: got %0d expected 1", step); end
    bus_read(16'h1020);
    checks++; if (step !== 2'd1) begin errors++; $display("FAIL overlap_restart: got %0d expected 1", step); end
    bus_read(16'h1090);
    checks++; if (step !== 2'd2) begin errors++; $display("FAIL overlap_continue: got %0d expected 2", step); end
    checks++; if (data_out !== 2'b10) begin errors++; $display("FAIL overlap_data: got %b expected 10", data_out); end
  endtask

  task automatic test_lockout();
    logic [15:0] seq_a [4];
    int bad;
    seq_a = '{16'h1020, 16'h1090, 16'h10A0, 16'h1080};
    apply_reset();
    bus_read(16'h1050);
    bus_read(16'h1050);
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL lockout_early: got %b expected 0", locked_out); end
    bus_read(16'h1050);
    checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lockout_enter: got %b expected 1", locked_out); end
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL lockout_enter_data: got %b expected 00", data_out); end
    // Lockout entry edge is E; E+1..E+63 stay locked, E+64 exits.
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      bus_read(seq_a[i]);
      if (locked_out !== 1'b1 || unlocked !== 1'b0 || step !== 2'd0 || data_out !== 2'b00) bad++;
    end
    for (int k = 5; k <= 63; k++) begin
      end_cycle();
      if (locked_out !== 1'b1 || unlocked !== 1'b0 || step !== 2'd0 || data_out !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lockout_hold: got %0d bad cycles expected 0", bad); end
    start_acc(16'h1020, 1'b1, 1'b1);
    checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lockout_last_cycle: got %b expected 1", locked_out); end
    end_cycle();
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL lockout_exit: got %b expected 0", locked_out); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL lockout_exit_acc_ignored: got %0d expected 0", step); end
    bus_read(16'h1020);
    checks++; if (step !== 2'd1) begin errors++; $display("FAIL lockout_rearmed: got %0d expected 1", step); end
  endtask

  task automatic test_idle();
    apply_reset();
    unlock_seq();
    idle_cycles(1023);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL idle_before: got %b expected 1", unlocked); end
    idle_cycles(1);
    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL idle_timeout: got %b expected 0", unlocked); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL idle_step: got %0d expected 0", step); end
    unlock_seq();
    idle_cycles(1023);
    bus_read(16'h1030);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL idle_access_wins: got %b expected 1", unlocked); end
    idle_cycles(1023);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL idle_reload_before: got %b expected 1", unlocked); end
    idle_cycles(1);
    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL idle_reload_timeout: got %b expected 0", unlocked); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus_read(16'h1020);
    bus_read(16'h1090);
    checks++; if (step !== 2'd2) begin errors++; $display("FAIL areset_pre_step: got %0d expected 2", step); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL areset_step: got %0d expected 0", step); end
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL areset_data: got %b expected 00", data_out); end
    #1;
    rst_n = 1'b1;
    unlock_seq();
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL areset_pre_open: got %b expected 1", unlocked); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL areset_unlocked: got %b expected 0", unlocked); end
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL areset_locked_out: got %b expected 0", locked_out); end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_ignore();
    test_overlap();
    test_lockout();
    test_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
